multiple_encoder5_3: RTL and testbench
======================================

// Module: multiple_encoder5_3
// PURPOSE
//   Receive-side partner of the 3->5 grouped active-low decoder. Samples five active-low
//   select lines, synchronises and debounces them, and checks for a legal one-cold pattern.
//   It encodes that pattern back to the 3-bit code group it represents.
//   Each qualified selection is delivered once via a VALID/READY handshake.
//   Each invalid pattern is flagged and counted.
// PARAMETERS
//   SYNC_STAGES    2   synchroniser depth on Y_N, legal 2..4
//   STABLE_CYCLES  4   consecutive identical synced samples needed to qualify, legal 1..255
// PORTS
//   CLK      in   1  single clock, rising edge
//   RST_N    in   1  asynchronous active-low reset
//   Y_N      in   5  active-low select lines, asynchronous to CLK
//   READY    in   1  consumer accepts CODE_LO/CODE_HI when high with VALID
//   VALID    out  1  CODE_LO/CODE_HI hold a qualified selection
//   CODE_LO  out  3  lowest code of the selected group
//   CODE_HI  out  3  highest code of the selected group
//   ERR      out  1  one-cycle pulse on detection of an illegal pattern
//   EVT_CNT  out  8  accepted-handshake count, wraps 255->0
//   ERR_CNT  out  8  illegal-pattern count, saturates at 255
// BEHAVIOUR
//   Reset (async assert, sync release): synchroniser flops=1, FSM=IDLE, cnt=0, VALID=0,
//     CODE_LO=CODE_HI=0, ERR=0, EVT_CNT=ERR_CNT=0.
//   Decode table for synced S. All other non-11111 values are illegal:
//     11110->LO0/HI1  11101->LO2/HI2  11011->LO3/HI5  10111->LO6/HI6  01111->LO7/HI7
//   States IDLE, QUALIFY, PRESENT, RELEASE. FSM reads only the synced S, one sample per clock.
//   IDLE:
//     S==11111 -> stay.
//     S legal -> capture P=S, cnt=1. Go to QUALIFY, or to PRESENT if STABLE_CYCLES==1.
//     S illegal -> ERR pulse, ERR_CNT+1 (saturating), go to RELEASE with cnt=0.
//   QUALIFY:
//     S==P -> if cnt+1==STABLE_CYCLES go to PRESENT, else cnt+1.
//     S==11111 -> IDLE.
//     S legal but !=P -> P=S, cnt=1 (restart).
//     S illegal -> ERR path as in IDLE.
//   PRESENT entry: CODE_LO/HI are registered from P. VALID=1 from the next cycle.
//     VALID and CODE_* stay constant until the READY handshake. Y_N activity is ignored.
//     VALID&READY at an edge -> EVT_CNT+1 (wrapping), VALID=0, go to RELEASE with cnt=0.
//     CODE_* retain their last value after VALID falls.
//   RELEASE:
//     S==11111 -> cnt+1. Reaching STABLE_CYCLES -> IDLE.
//     Any other S -> cnt=0. Illegal S here gives no ERR and no count.
//   Latency: with Y_N stable before edge e0, VALID is high after edge e0+SYNC_STAGES+STABLE_CYCLES-1.
//     Example: SYNC_STAGES=2, STABLE_CYCLES=4 -> VALID high after 6 edges.
//   A selection held asserted produces exactly one event. A new event needs Y_N
//     released (11111) for STABLE_CYCLES samples first.
//   READY high before VALID has no effect. The handshake completes on the first edge with both high.
//   Reset mid-handshake drops VALID immediately. The event is not counted.
//   Simultaneous ERR and handshake cannot occur: they come from exclusive states.
// TESTING
//   Defaults. Y_N=11011 held, READY=1 -> one VALID cycle 6 edges later, LO=3 HI=5, EVT_CNT=1, no second event.
//   Y_N=11110 for 3 cycles then 11101 held -> qualify restarts.
//     Single event LO=2 HI=2, never LO=0.
//   Y_N=11100 -> ERR single-cycle pulse, ERR_CNT=1, VALID stays 0.
//     Y_N=11111 for 4 cycles returns to IDLE.
//   Y_N=01111 with READY=0 for 20 cycles -> VALID and LO=HI=7 held.
//     READY=1 -> VALID low next cycle, EVT_CNT+1.
//   Counters: 256 accepted events -> EVT_CNT wraps to 0. 300 illegal events -> ERR_CNT stays 255.
//   RST_N low while VALID=1 -> all outputs reset asynchronously.
//     Y_N still low after release -> one new event after the full latency.

Source files
------------

// File: rtl/multiple_encoder5_3_if.sv
`default_nettype none
// ============================================================================
// Module      : multiple_encoder5_3_if
// Description : Select-line input, code handshake and status bundle for the
//               5->3 grouped active-low encoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface multiple_encoder5_3_if;
    logic [4:0] y_n;
    logic       ready;
    logic       valid;
    logic [2:0] code_lo;
    logic [2:0] code_hi;
    logic       err;
    logic [7:0] evt_cnt;
    logic [7:0] err_cnt;

    // Encoder side: drives the code, status and counters.
    modport master (
        input  y_n,
        input  ready,
        output valid,
        output code_lo,
        output code_hi,
        output err,
        output evt_cnt,
        output err_cnt
    );

    // Environment side: drives the select lines and consumes the code.
    modport slave (
        output y_n,
        output ready,
        input  valid,
        input  code_lo,
        input  code_hi,
        input  err,
        input  evt_cnt,
        input  err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/multiple_encoder5_3.sv
`default_nettype none
// ============================================================================
// Module      : multiple_encoder5_3
// Description : Synchronises and debounces five active-low select lines,
//               encodes a legal one-cold pattern to its code group and
//               delivers it once per selection over VALID/READY.
// Revision    : 1.0 - initial release
// ============================================================================
module multiple_encoder5_3 #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    multiple_encoder5_3_if.master bus
);

    localparam logic [4:0] c_released = 5'b11111;
    localparam logic [8:0] c_stable   = 9'(STABLE_CYCLES);
    localparam bit         c_one_shot = (STABLE_CYCLES == 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_QUALIFY = 2'd1,
        S_PRESENT = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    function automatic logic is_legal(input logic [4:0] s);
        case (s)
            5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111: return 1'b1;
            default:                                           return 1'b0;
        endcase
    endfunction

    // Returns {code_lo, code_hi}; only called with legal patterns.
    function automatic logic [5:0] decode(input logic [4:0] s);
        case (s)
            5'b11110: return {3'd0, 3'd1};
            5'b11101: return {3'd2, 3'd2};
            5'b11011: return {3'd3, 3'd5};
            5'b10111: return {3'd6, 3'd6};
            5'b01111: return {3'd7, 3'd7};
            default:  return 6'd0;
        endcase
    endfunction

    logic [SYNC_STAGES-1:0][4:0] r_sync;
    state_t     r_state;
    logic [7:0] r_cnt;
    logic [4:0] r_pat;
    logic       r_valid;
    logic [2:0] r_code_lo;
    logic [2:0] r_code_hi;
    logic       r_err;
    logic [7:0] r_evt_cnt;
    logic [7:0] r_err_cnt;

    state_t     w_state_nxt;
    logic [7:0] w_cnt_nxt;
    logic [4:0] w_pat_nxt;
    logic       w_valid_nxt;
    logic [2:0] w_code_lo_nxt;
    logic [2:0] w_code_hi_nxt;
    logic       w_err_nxt;
    logic [7:0] w_evt_cnt_nxt;
    logic [7:0] w_err_cnt_nxt;

    logic [4:0] w_s;
    logic [8:0] w_cnt_inc;

    assign w_s       = r_sync[SYNC_STAGES-1];
    assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;

    // Reset to all-ones so a reset never looks like a selection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{c_released}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.y_n};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_pat     <= c_released;
            r_valid   <= 1'b0;
            r_code_lo <= 3'd0;
            r_code_hi <= 3'd0;
            r_err     <= 1'b0;
            r_evt_cnt <= 8'd0;
            r_err_cnt <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pat     <= w_pat_nxt;
            r_valid   <= w_valid_nxt;
            r_code_lo <= w_code_lo_nxt;
            r_code_hi <= w_code_hi_nxt;
            r_err     <= w_err_nxt;
            r_evt_cnt <= w_evt_cnt_nxt;
            r_err_cnt <= w_err_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pat_nxt     = r_pat;
        w_valid_nxt   = r_valid;
        w_code_lo_nxt = r_code_lo;
        w_code_hi_nxt = r_code_hi;
        w_err_nxt     = 1'b0;
        w_evt_cnt_nxt = r_evt_cnt;
        w_err_cnt_nxt = r_err_cnt;

        unique case (r_state)
            S_IDLE: begin
                if (w_s == c_released) begin
                    w_state_nxt = S_IDLE;
                end else if (is_legal(w_s)) begin
                    w_pat_nxt = w_s;
                    w_cnt_nxt = 8'd1;
                    if (c_one_shot) begin
                        w_state_nxt                    = S_PRESENT;
                        w_valid_nxt                    = 1'b1;
                        {w_code_lo_nxt, w_code_hi_nxt} = decode(w_s);
                    end else begin
                        w_state_nxt = S_QUALIFY;
                    end
                end else begin
                    w_err_nxt     = 1'b1;
                    w_err_cnt_nxt = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;
                    w_state_nxt   = S_RELEASE;
                    w_cnt_nxt     = 8'd0;
                end
            end

            S_QUALIFY: begin
                if (w_s == r_pat) begin
                    if (w_cnt_inc == c_stable) begin
                        w_state_nxt                    = S_PRESENT;
                        w_valid_nxt                    = 1'b1;
                        {w_code_lo_nxt, w_code_hi_nxt} = decode(r_pat);
                    end else begin
                        w_cnt_nxt = w_cnt_inc[7:0];
                    end
                end else if (w_s == c_released) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 8'd0;
                end else if (is_legal(w_s)) begin
                    w_pat_nxt = w_s;
                    w_cnt_nxt = 8'd1;
                end else begin
                    w_err_nxt     = 1'b1;
                    w_err_cnt_nxt = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;
                    w_state_nxt   = S_RELEASE;
                    w_cnt_nxt     = 8'd0;
                end
            end

            // Select lines are ignored while a code is on offer.
            S_PRESENT: begin
                if (r_valid && bus.ready) begin
                    w_evt_cnt_nxt = r_evt_cnt + 8'd1;
                    w_valid_nxt   = 1'b0;
                    w_state_nxt   = S_RELEASE;
                    w_cnt_nxt     = 8'd0;
                end
            end

            S_RELEASE: begin
                if (w_s == c_released) begin
                    if (w_cnt_inc == c_stable) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc[7:0];
                    end
                end else begin
                    w_cnt_nxt = 8'd0;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    assign bus.valid   = r_valid;
    assign bus.code_lo = r_code_lo;
    assign bus.code_hi = r_code_hi;
    assign bus.err     = r_err;
    assign bus.evt_cnt = r_evt_cnt;
    assign bus.err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_multiple_encoder5_3.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiple_encoder5_3
// Description : Directed self-checking bench for multiple_encoder5_3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiple_encoder5_3;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    multiple_encoder5_3_if bus ();

    multiple_encoder5_3 #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until VALID is seen; n=0 means the bound expired.
    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic settle_release();
        bus.y_n = 5'b11111;
        repeat (8) tick();
    endtask

    task automatic do_event(input logic [4:0] v);
        int n;
        bus.y_n   = v;
        bus.ready = 1'b1;
        wait_valid(n);
        if (n == 0) begin
            total++; bad++;
            $display("FAIL do_event_timeout: valid never rose for y_n=%b", v);
        end
        tick();
        settle_release();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.y_n   = 5'b11111;
        bus.ready = 1'b0;
        repeat (3) tick();
        total++;
        if ({bus.valid, bus.code_lo, bus.code_hi, bus.err, bus.evt_cnt, bus.err_cnt} !== 24'd0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b lo=%0d hi=%0d e=%b evt=%0d errc=%0d want all 0",
                     bus.valid, bus.code_lo, bus.code_hi, bus.err, bus.evt_cnt, bus.err_cnt);
        end
        rst_n = 1'b1;
        repeat (4) tick();
        total++;
        if (bus.valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_valid: got %b want 0", bus.valid);
        end
    endtask

    task automatic test_basic();
        int n;
        int extra;
        bus.ready = 1'b1;
        bus.y_n   = 5'b11011;
        wait_valid(n);
        total++;
        if (n != 6) begin
            bad++;
            $display("FAIL basic_latency: got %0d edges want 6", n);
        end
        total++;
        if (bus.code_lo !== 3'd3 || bus.code_hi !== 3'd5) begin
            bad++;
            $display("FAIL basic_code: got lo=%0d hi=%0d want lo=3 hi=5", bus.code_lo, bus.code_hi);
        end
        tick();
        total++;
        if (bus.valid !== 1'b0 || bus.evt_cnt !== 8'd1) begin
            bad++;
            $display("FAIL basic_handshake: got valid=%b evt=%0d want valid=0 evt=1", bus.valid, bus.evt_cnt);
        end
        extra = 0;
        repeat (30) begin
            tick();
            if (bus.valid === 1'b1) extra++;
        end
        total++;
        if (extra != 0 || bus.evt_cnt !== 8'd1) begin
            bad++;
            $display("FAIL basic_single_event: got extra=%0d evt=%0d want extra=0 evt=1", extra, bus.evt_cnt);
        end
        settle_release();
    endtask

    task automatic test_restart();
        int good;
        int wrong;
        bus.ready = 1'b1;
        bus.y_n   = 5'b11110;
        repeat (3) tick();
        bus.y_n = 5'b11101;
        good  = 0;
        wrong = 0;
        repeat (25) begin
            tick();
            if (bus.valid === 1'b1) begin
                if (bus.code_lo === 3'd2 && bus.code_hi === 3'd2) good++;
                else wrong++;
            end
        end
        total++;
        if (good != 1 || wrong != 0) begin
            bad++;
            $display("FAIL restart_event: got good=%0d wrong=%0d want good=1 wrong=0", good, wrong);
        end
        total++;
        if (bus.evt_cnt !== 8'd2) begin
            bad++;
            $display("FAIL restart_evt_cnt: got %0d want 2", bus.evt_cnt);
        end
        settle_release();
    endtask

    task automatic test_error();
        int pulses;
        int valids;
        int n;
        bus.ready = 1'b1;
        bus.y_n   = 5'b11100;
        pulses = 0;
        valids = 0;
        repeat (12) begin
            tick();
            if (bus.err === 1'b1) pulses++;
            if (bus.valid === 1'b1) valids++;
        end
        total++;
        if (pulses != 1 || valids != 0) begin
            bad++;
            $display("FAIL error_pulse: got pulses=%0d valids=%0d want 1 and 0", pulses, valids);
        end
        total++;
        if (bus.err_cnt !== 8'd1) begin
            bad++;
            $display("FAIL error_count: got %0d want 1", bus.err_cnt);
        end
        bus.y_n = 5'b11111;
        repeat (2 + 4) tick();
        bus.y_n = 5'b10111;
        wait_valid(n);
        total++;
        if (n != 6 || bus.code_lo !== 3'd6 || bus.code_hi !== 3'd6) begin
            bad++;
            $display("FAIL error_recover: got n=%0d lo=%0d hi=%0d want n=6 lo=6 hi=6", n, bus.code_lo, bus.code_hi);
        end
        tick();
        settle_release();
    endtask

    task automatic test_hold();
        int n;
        int drift;
        bus.ready = 1'b0;
        bus.y_n   = 5'b01111;
        wait_valid(n);
        total++;
        if (n != 6) begin
            bad++;
            $display("FAIL hold_latency: got %0d want 6", n);
        end
        drift = 0;
        for (int i = 0; i < 20; i++) begin
            bus.y_n = (i < 10) ? 5'b11110 : 5'b01111;
            tick();
            if (bus.valid !== 1'b1 || bus.code_lo !== 3'd7 || bus.code_hi !== 3'd7 || bus.evt_cnt !== 8'd3)
                drift++;
        end
        total++;
        if (drift != 0) begin
            bad++;
            $display("FAIL hold_stable: got %0d drifting cycles want 0", drift);
        end
        bus.ready = 1'b1;
        tick();
        total++;
        if (bus.valid !== 1'b0 || bus.evt_cnt !== 8'd4 || bus.code_lo !== 3'd7 || bus.code_hi !== 3'd7) begin
            bad++;
            $display("FAIL hold_accept: got v=%b evt=%0d lo=%0d hi=%0d want v=0 evt=4 lo=7 hi=7",
                     bus.valid, bus.evt_cnt, bus.code_lo, bus.code_hi);
        end
        settle_release();
    endtask

    task automatic test_reset_mid();
        int n;
        bus.ready = 1'b0;
        bus.y_n   = 5'b11011;
        wait_valid(n);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.valid !== 1'b0 || bus.evt_cnt !== 8'd0 || bus.code_lo !== 3'd0 || bus.code_hi !== 3'd0 ||
            bus.err_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_mid_async: got v=%b evt=%0d lo=%0d hi=%0d errc=%0d want all 0",
                     bus.valid, bus.evt_cnt, bus.code_lo, bus.code_hi, bus.err_cnt);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        wait_valid(n);
        total++;
        if (n != 6 || bus.code_lo !== 3'd3 || bus.code_hi !== 3'd5 || bus.evt_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_mid_reevent: got n=%0d lo=%0d hi=%0d evt=%0d want n=6 lo=3 hi=5 evt=0",
                     n, bus.code_lo, bus.code_hi, bus.evt_cnt);
        end
        bus.ready = 1'b1;
        tick();
        total++;
        if (bus.evt_cnt !== 8'd1) begin
            bad++;
            $display("FAIL reset_mid_count: got %0d want 1", bus.evt_cnt);
        end
        settle_release();
    endtask

    task automatic test_counters();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 255; i++) do_event(5'b11110);
        total++;
        if (bus.evt_cnt !== 8'd255) begin
            bad++;
            $display("FAIL evt_cnt_255: got %0d want 255", bus.evt_cnt);
        end
        do_event(5'b01111);
        total++;
        if (bus.evt_cnt !== 8'd0) begin
            bad++;
            $display("FAIL evt_cnt_wrap: got %0d want 0", bus.evt_cnt);
        end
        for (int i = 0; i < 300; i++) begin
            bus.y_n = 5'b00000;
            repeat (4) tick();
            settle_release();
            if (i == 253) begin
                total++;
                if (bus.err_cnt !== 8'd254) begin
                    bad++;
                    $display("FAIL err_cnt_254: got %0d want 254", bus.err_cnt);
                end
            end
        end
        total++;
        if (bus.err_cnt !== 8'd255 || bus.evt_cnt !== 8'd0) begin
            bad++;
            $display("FAIL err_cnt_saturate: got errc=%0d evt=%0d want 255 and 0", bus.err_cnt, bus.evt_cnt);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_restart();
        test_error();
        test_hold();
        test_reset_mid();
        test_counters();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
